// File: rtl/cvw.sv
// Shared cvw package: core configuration record plus the debug-hart state and halt-cause encodings.
package cvw;

  typedef struct packed {
    int unsigned XLEN;
    logic [1:0]  M_MODE;
    logic [1:0]  S_MODE;
    logic [1:0]  U_MODE;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, M_MODE: 2'b11, S_MODE: 2'b01, U_MODE: 2'b00};

  typedef enum logic [2:0] {
    RUNNING,
    HALTING,
    HALTED,
    RESUMING,
    STEPPING
  } dbgState_t;

  localparam logic [2:0] DBG_CAUSE_NONE      = 3'd0;
  localparam logic [2:0] DBG_CAUSE_EBREAK    = 3'd1;
  localparam logic [2:0] DBG_CAUSE_HALTREQ   = 3'd3;
  localparam logic [2:0] DBG_CAUSE_STEP      = 3'd4;
  localparam logic [2:0] DBG_CAUSE_RESETHALT = 3'd5;

endpackage

// File: rtl/dbgcausesel.sv
// Debug-entry cause priority encode: ebreak > resethaltreq > haltreq > step.
module dbgcausesel
  import cvw::*;
(
  input  logic       ebreak,
  input  logic       resetHalt,
  input  logic       haltReq,
  input  logic       step,
  output logic [2:0] cause
);

  always_comb begin
    if (ebreak)         cause = DBG_CAUSE_EBREAK;
    else if (resetHalt) cause = DBG_CAUSE_RESETHALT;
    else if (haltReq)   cause = DBG_CAUSE_HALTREQ;
    else if (step)      cause = DBG_CAUSE_STEP;
    else                cause = DBG_CAUSE_NONE;
  end

endmodule

// File: rtl/debug_hart_ctrl.sv
// Hart-side debug mode controller: halt/resume/single-step sequencing and cause reporting.
// Optional feature: DEBUG_RESETHALTREQ_EN lets HaltOnReset send the hart into debug out of reset.
//
// state    | meaning
// RUNNING  | normal execution
// HALTING  | fetch stalled, waiting for the pipeline to drain
// HALTED   | in debug mode, parked
// RESUMING | one-cycle redirect to DPC and acknowledge
// STEPPING | running until exactly one instruction retires
module debug_hart_ctrl
  import cvw::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       HaltReq,
  input  logic       ResumeReq,
  input  logic       HaltOnReset,
  input  logic       Step,
  input  logic       ebreakM,
  input  logic       ebreakEn,
  input  logic       InstrRetiredM,
  input  logic       PipeIdle,
  output logic       DebugMode,
  output logic       DCall,
  output logic [2:0] DebugCause,
  output logic       HaltPipe,
  output logic       ResumeM,
  output logic       ResumeAck,
  output logic       Halted
);

  if (P.XLEN != 32 && P.XLEN != 64) begin : gBadXlen
    $error("debug_hart_ctrl: unsupported XLEN");
  end

  dbgState_t state, stateNext;
  logic       pendReset, pendHalt, pendStep;
  logic [2:0] causeReg, selCause;
  logic       ebreakHit, resetHalt;

`ifdef DEBUG_RESETHALTREQ_EN
  assign resetHalt = HaltOnReset;
`else
  logic unusedHaltOnReset;
  assign unusedHaltOnReset = HaltOnReset;
  assign resetHalt = 1'b0;
`endif

  assign ebreakHit = ebreakM & ebreakEn & ((state == RUNNING) | (state == STEPPING));

  dbgcausesel u_causesel (
    .ebreak   (ebreakHit),
    .resetHalt(pendReset),
    .haltReq  (pendHalt),
    .step     (pendStep),
    .cause    (selCause)
  );

  // Every output is forced low while reset is held so an abandoned sequence leaves no strobe behind.
  assign DCall      = ~reset & (ebreakHit | ((state == HALTING) & PipeIdle));
  assign DebugCause = reset ? DBG_CAUSE_NONE : (DCall ? selCause : causeReg);
  assign DebugMode  = ~reset & ((state == HALTED) | (state == RESUMING));
  assign Halted     = ~reset & (state == HALTED);
  assign HaltPipe   = ~reset & (state == HALTING);
  assign ResumeM    = ~reset & (state == RESUMING);
  assign ResumeAck  = ~reset & (state == RESUMING);

  always_comb begin
    stateNext = state;
    case (state)
      RUNNING:  if (ebreakHit) stateNext = HALTED;
                else if (HaltReq) stateNext = HALTING;
      HALTING:  if (PipeIdle) stateNext = HALTED;
      HALTED:   if (ResumeReq & ~HaltReq) stateNext = RESUMING;
      RESUMING: stateNext = Step ? STEPPING : RUNNING;
      STEPPING: if (ebreakHit) stateNext = HALTED;
                else if (InstrRetiredM) stateNext = HALTING;
      default:  stateNext = RUNNING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= resetHalt ? HALTING : RUNNING;
      pendReset <= resetHalt;
      pendHalt  <= 1'b0;
      pendStep  <= 1'b0;
      causeReg  <= DBG_CAUSE_NONE;
    end else begin
      state <= stateNext;
      if (DCall) begin
        causeReg  <= selCause;
        pendReset <= 1'b0;
        pendHalt  <= 1'b0;
        pendStep  <= 1'b0;
      end else begin
        // A halt request only upgrades a step if it is seen before the retiring cycle.
        if ((state == RUNNING) & HaltReq) pendHalt <= 1'b1;
        if ((state == STEPPING) & HaltReq & ~InstrRetiredM) pendHalt <= 1'b1;
        if ((state == STEPPING) & InstrRetiredM) pendStep <= 1'b1;
      end
    end
  end

endmodule
